// File: rtl/bt656_src_switcher.sv
// rtl/bt656_src_switcher.sv - frame-aligned source switch for genlocked BT.656 streams
// Parses TRS codes on the selected source and defers source changes to the F 1->0 EAV.
module bt656_src_switcher #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_SRC     = 2,
    parameter int SRC_W       = $clog2(NUM_SRC),
    parameter int TRS_TIMEOUT = 2048
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic                          req_valid,
    input  logic [SRC_W-1:0]              req_src,
    output logic [DATA_WIDTH-1:0]         data,
    output logic [SRC_W-1:0]              cur_src,
    output logic                          switch_pending,
    output logic                          switch_done,
    output logic                          sync_lock,
    output logic                          trs_error,
    output logic                          field,
    output logic                          vblank
);

    localparam int                CNT_W     = $clog2(TRS_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TRS_TIMEOUT - 1);
    localparam logic [SRC_W:0]    SRC_LIMIT = (SRC_W + 1)'(NUM_SRC);

    typedef enum logic [1:0] {
        P_IDLE,
        P_FF,
        P_00A,
        P_XY
    } parse_state_t;

    parse_state_t           state;
    parse_state_t           state_next;
    logic [DATA_WIDTH-1:0]  sel_byte;
    logic [7:0]             xy;
    logic                   xy_f;
    logic                   xy_v;
    logic                   xy_h;
    logic                   xy_ok;
    logic                   xy_valid;
    logic                   xy_error;
    logic                   boundary;
    logic                   apply_switch;
    logic [SRC_W-1:0]       cur_next;
    logic [SRC_W-1:0]       target;
    logic                   req_ok;
    logic [CNT_W-1:0]       timeout_cnt;

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cur_src == SRC_W'(i)) begin
                sel_byte = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // For wider-than-8-bit streams the TRS code lives in the top byte.
    assign xy    = sel_byte[DATA_WIDTH-1 -: 8];
    assign xy_f  = xy[6];
    assign xy_v  = xy[5];
    assign xy_h  = xy[4];
    assign xy_ok = xy[7]
                 && (xy[3] == (xy_v ^ xy_h))
                 && (xy[2] == (xy_f ^ xy_h))
                 && (xy[1] == (xy_f ^ xy_v))
                 && (xy[0] == (xy_f ^ xy_v ^ xy_h));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= P_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = P_IDLE;
        if (sel_byte == {DATA_WIDTH{1'b1}}) begin
            state_next = P_FF;
        end else begin
            case (state)
                P_FF:    if (sel_byte == '0) state_next = P_00A;
                P_00A:   if (sel_byte == '0) state_next = P_XY;
                default: state_next = P_IDLE;
            endcase
        end
    end

    always_comb begin
        xy_valid = 1'b0;
        xy_error = 1'b0;
        if (state == P_XY) begin
            xy_valid = xy_ok;
            xy_error = !xy_ok;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
        end else begin
            data <= sel_byte;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timeout_cnt <= '0;
            sync_lock   <= 1'b0;
            trs_error   <= 1'b0;
            field       <= 1'b0;
            vblank      <= 1'b1;
        end else begin
            trs_error <= xy_error;
            if (xy_valid) begin
                timeout_cnt <= '0;
                sync_lock   <= 1'b1;
                field       <= xy_f;
                vblank      <= xy_v;
            end else begin
                if (timeout_cnt != CNT_MAX) begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                end
                if (xy_error || (timeout_cnt == CNT_MAX)) begin
                    sync_lock <= 1'b0;
                end
            end
        end
    end

    // Without lock there is no frame to tear, so a pending switch goes immediately.
    assign boundary     = xy_valid && xy_h && !xy_f && field;
    assign apply_switch = switch_pending && (boundary || !sync_lock);
    assign cur_next     = apply_switch ? target : cur_src;
    assign req_ok       = req_valid && ({1'b0, req_src} < SRC_LIMIT);

    // A request landing on the boundary clock is judged against the post-switch source.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_src        <= '0;
            target         <= '0;
            switch_pending <= 1'b0;
            switch_done    <= 1'b0;
        end else begin
            cur_src     <= cur_next;
            switch_done <= apply_switch;
            if (req_ok) begin
                if (req_src == cur_next) begin
                    switch_pending <= 1'b0;
                end else begin
                    target         <= req_src;
                    switch_pending <= 1'b1;
                end
            end else if (apply_switch) begin
                switch_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bt656_src_switcher.sv
// tb/tb_bt656_src_switcher.sv - randomized self-checking bench for bt656_src_switcher
// Miniature genlocked frames keep the run short; a stream-level reference model predicts every output.
module tb_bt656_src_switcher;

    localparam int DW       = 8;
    localparam int NS       = 2;
    localparam int SW       = 2;
    localparam int TO       = 2048;
    localparam int LINE_LEN = 64;
    localparam int LINES    = 20;
    localparam int FRAME    = LINE_LEN * LINES;
    localparam logic [15:0] RESET_VEC = 16'h0001;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [NS*DW-1:0]  src_data;
    logic              req_valid;
    logic [SW-1:0]     req_src;
    logic [DW-1:0]     data;
    logic [SW-1:0]     cur_src;
    logic              switch_pending;
    logic              switch_done;
    logic              sync_lock;
    logic              trs_error;
    logic              field;
    logic              vblank;
    logic [15:0]       obs;

    always #5 clock = ~clock;

    bt656_src_switcher #(
        .DATA_WIDTH(DW), .NUM_SRC(NS), .SRC_W(SW), .TRS_TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .src_data(src_data),
        .req_valid(req_valid), .req_src(req_src), .data(data), .cur_src(cur_src),
        .switch_pending(switch_pending), .switch_done(switch_done), .sync_lock(sync_lock),
        .trs_error(trs_error), .field(field), .vblank(vblank)
    );

    assign obs = {data, cur_src, switch_pending, switch_done, sync_lock, trs_error, field, vblank};

    int checks = 0;
    int errors = 0;
    int line = 0;
    int pos = 0;
    bit hold0 = 1'b0;
    bit corrupt = 1'b0;

    logic [7:0]    m_data;
    logic [SW-1:0] m_cur;
    logic [SW-1:0] m_target;
    bit            m_pending, m_done, m_lock, m_err, m_field, m_vblank;
    int            m_since;
    logic [7:0]    h0, h1, h2;

    function automatic logic [7:0] xy_code(logic f, logic v, logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    function automatic logic [7:0] gen_byte(int s, int ln, int p);
        logic f, v;
        f = (ln >= LINES / 2);
        v = ((ln % (LINES / 2)) >= (LINES / 2 - 2));
        case (p)
            0, 12:         return 8'hFF;
            1, 2, 13, 14:  return 8'h00;
            3:             return xy_code(f, v, 1'b1);
            15:            return xy_code(f, v, 1'b0);
            default:       ;
        endcase
        if (p < 12) return (((p % 2) == 0) == (s == 0)) ? 8'h80 : 8'h10;
        if (s == 1) return 8'(ln + 1);
        return 8'(64 + p % 32);
    endfunction

    function automatic logic [15:0] exp_vec();
        return {m_data, m_cur, m_pending, m_done, m_lock, m_err, m_field, m_vblank};
    endfunction

    task automatic drive_src();
        logic [7:0] b;
        for (int s = 0; s < NS; s++) begin
            b = gen_byte(s, line, pos);
            if (s == 0 && hold0) b = 8'h80;
            if (corrupt && pos == 3) b = 8'h9E;
            src_data[s*DW +: DW] = b;
        end
    endtask

    task automatic model_reset();
        m_data = 8'h00; m_cur = '0; m_target = '0; m_pending = 0; m_done = 0;
        m_lock = 0; m_err = 0; m_field = 0; m_vblank = 1; m_since = 0;
        h0 = 8'h00; h1 = 8'h00; h2 = 8'h00;
    endtask

    // One clock: sample what the DUT sees, advance the reference model, then present the next byte.
    task automatic tick();
        logic [7:0]    b;
        logic          rv;
        logic [SW-1:0] rs;
        logic [SW-1:0] nc;
        bit            is_trs, valid, err, bnd, apply;
        b  = src_data[m_cur*DW +: DW];
        rv = req_valid;
        rs = req_src;
        @(posedge clock);
        #1;
        if (!reset_n) begin
            model_reset();
        end else begin
            is_trs = (h2 == 8'hFF) && (h1 == 8'h00) && (h0 == 8'h00);
            valid  = is_trs && b[7] && (b == xy_code(b[6], b[5], b[4]));
            err    = is_trs && !valid;
            bnd    = valid && b[4] && !b[6] && m_field;
            apply  = m_pending && (bnd || !m_lock);
            nc     = apply ? m_target : m_cur;
            m_data = b;
            m_done = apply;
            m_err  = err;
            if (apply) m_pending = 0;
            m_cur = nc;
            if (rv && (int'(rs) < NS)) begin
                if (rs == nc) m_pending = 0;
                else begin m_target = rs; m_pending = 1; end
            end
            m_since++;
            if (valid) begin
                m_lock = 1; m_since = 0; m_field = b[6]; m_vblank = b[5];
            end else if (err || m_since >= TO) begin
                m_lock = 0;
            end
            h2 = h1; h1 = h0; h0 = b;
        end
        if (corrupt && pos == 3) corrupt = 0;
        pos++;
        if (pos == LINE_LEN) begin pos = 0; line = (line + 1) % LINES; end
        req_valid = 1'b0;
        drive_src();
    endtask

    task automatic run_until(int ln, int p);
        while (!(line == ln && pos == p)) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; req_src = '0; line = 0; pos = 0;
        model_reset();
        drive_src();
        repeat (3) tick();
        checks++;
        if (obs !== RESET_VEC) begin
            errors++; $display("FAIL reset_values got %h exp %h", obs, RESET_VEC);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 2 * LINE_LEN; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL passthrough t=%0t got %h exp %h", $time, obs, exp_vec());
            end
        end
        checks++;
        if (sync_lock !== 1'b1 || cur_src !== 2'd0) begin
            errors++; $display("FAIL initial_lock got lock=%b cur=%0d exp lock=1 cur=0", sync_lock, cur_src);
        end
    endtask

    task automatic test_switch();
        int done_seen = 0;
        run_until(3, 20);
        req_valid = 1'b1; req_src = 2'd1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL switch_stream t=%0t got %h exp %h", $time, obs, exp_vec());
            end
            if (switch_done) begin
                done_seen++;
                checks++;
                if (data !== 8'h9D || cur_src !== 2'd1) begin
                    errors++; $display("FAIL switch_boundary got data=%h cur=%0d exp data=9d cur=1", data, cur_src);
                end
                break;
            end
        end
        checks++;
        if (done_seen != 1) begin
            errors++; $display("FAIL switch_timeout got %0d done pulses exp 1", done_seen);
        end
        tick();
        checks++;
        if (data !== 8'h10 || switch_done !== 1'b0) begin
            errors++; $display("FAIL switch_next_byte got data=%h done=%b exp data=10 done=0", data, switch_done);
        end
    endtask

    task automatic test_cancel();
        logic [SW-1:0] home, other;
        int done_cnt = 0;
        home = m_cur; other = m_cur ^ 2'd1;
        run_until(3, 20);
        req_valid = 1'b1; req_src = other;
        tick();
        checks++;
        if (switch_pending !== 1'b1) begin
            errors++; $display("FAIL cancel_pending_set got %b exp 1", switch_pending);
        end
        repeat (2 * LINE_LEN) tick();
        req_valid = 1'b1; req_src = home;
        tick();
        checks++;
        if (switch_pending !== 1'b0) begin
            errors++; $display("FAIL cancel_pending_clr got %b exp 0", switch_pending);
        end
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (switch_done) done_cnt++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL cancel_stream t=%0t got %h exp %h", $time, obs, exp_vec());
            end
        end
        checks++;
        if (done_cnt != 0 || cur_src !== home) begin
            errors++; $display("FAIL cancel_no_switch got done=%0d cur=%0d exp done=0 cur=%0d", done_cnt, cur_src, home);
        end
        req_valid = 1'b1; req_src = other;
        repeat (10) tick();
        req_valid = 1'b1; req_src = other;
        for (int i = 0; i < FRAME + LINE_LEN; i++) begin
            tick();
            if (switch_done) done_cnt++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL repeat_stream t=%0t got %h exp %h", $time, obs, exp_vec());
            end
        end
        checks++;
        if (done_cnt != 1 || cur_src !== other) begin
            errors++; $display("FAIL repeat_single got done=%0d cur=%0d exp done=1 cur=%0d", done_cnt, cur_src, other);
        end
    endtask

    task automatic test_corrupt();
        int err_cnt = 0;
        run_until(12, 0);
        corrupt = 1'b1;
        drive_src();
        for (int i = 0; i < LINE_LEN; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL corrupt_stream t=%0t got %h exp %h", $time, obs, exp_vec());
            end
            if (trs_error) begin
                err_cnt++;
                checks++;
                if (sync_lock !== 1'b0 || field !== 1'b1) begin
                    errors++; $display("FAIL corrupt_state got lock=%b field=%b exp lock=0 field=1", sync_lock, field);
                end
            end
        end
        checks++;
        if (err_cnt != 1 || sync_lock !== 1'b1) begin
            errors++; $display("FAIL corrupt_relock got errs=%0d lock=%b exp errs=1 lock=1", err_cnt, sync_lock);
        end
    endtask

    task automatic test_timeout();
        int done_cnt = 0;
        if (m_cur != 0) begin
            req_valid = 1'b1; req_src = 2'd0;
            for (int i = 0; i < 2 * FRAME; i++) begin
                tick();
                checks++;
                if (obs !== exp_vec()) begin
                    errors++; $display("FAIL timeout_prep t=%0t got %h exp %h", $time, obs, exp_vec());
                end
                if (switch_done) break;
            end
        end
        hold0 = 1'b1;
        drive_src();
        for (int i = 0; i < TO + LINE_LEN; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL timeout_stream t=%0t got %h exp %h", $time, obs, exp_vec());
            end
        end
        checks++;
        if (sync_lock !== 1'b0 || cur_src !== 2'd0) begin
            errors++; $display("FAIL timeout_unlock got lock=%b cur=%0d exp lock=0 cur=0", sync_lock, cur_src);
        end
        req_valid = 1'b1; req_src = 2'd2;
        tick();
        checks++;
        if (switch_pending !== 1'b0 || cur_src !== 2'd0) begin
            errors++; $display("FAIL ignore_bad_src got pend=%b cur=%0d exp pend=0 cur=0", switch_pending, cur_src);
        end
        req_valid = 1'b1; req_src = 2'd1;
        repeat (2) begin
            tick();
            if (switch_done) done_cnt++;
        end
        checks++;
        if (cur_src !== 2'd1 || done_cnt != 1) begin
            errors++; $display("FAIL unlocked_switch got cur=%0d done=%0d exp cur=1 done=1", cur_src, done_cnt);
        end
        hold0 = 1'b0;
        drive_src();
        for (int i = 0; i < LINE_LEN; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL timeout_relock t=%0t got %h exp %h", $time, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3 * FRAME; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                req_valid = 1'b1;
                req_src   = SW'($urandom_range(0, 3));
            end
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random_stream t=%0t got %h exp %h", $time, obs, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        int done_cnt = 0;
        run_until(5, 0);
        req_valid = 1'b1; req_src = m_cur ^ 2'd1;
        tick();
        run_until(0, 2);
        checks++;
        if (switch_pending !== 1'b1) begin
            errors++; $display("FAIL areset_pending got %b exp 1", switch_pending);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== RESET_VEC) begin
            errors++; $display("FAIL areset_async got %h exp %h", obs, RESET_VEC);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (switch_done) done_cnt++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL areset_stream t=%0t got %h exp %h", $time, obs, exp_vec());
            end
        end
        checks++;
        if (done_cnt != 0 || cur_src !== 2'd0 || sync_lock !== 1'b1) begin
            errors++; $display("FAIL areset_stale got done=%0d cur=%0d lock=%b exp 0 0 1", done_cnt, cur_src, sync_lock);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_switch();
        test_cancel();
        test_corrupt();
        test_timeout();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

endmodule
